// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice built from two half adders,
// iterated LSB-first with a carry flop, behind a start/busy/done handshake.

module half_adder (
  input  logic a,
  input  logic b,
  output logic Sum,
  output logic Carry
);

  assign Sum   = a ^ b;
  assign Carry = a & b;

endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             V
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PenCnt  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] ra, rb, rs;
  logic [WIDTH-1:0] rs_d;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             cmsb;
  logic             accept;

  logic ha0_sum, ha0_carry, ha1_sum, ha1_carry;
  logic s, co;

  half_adder u_ha0 (
    .a     (ra[0]),
    .b     (rb[0]),
    .Sum   (ha0_sum),
    .Carry (ha0_carry)
  );

  half_adder u_ha1 (
    .a     (ha0_sum),
    .b     (c),
    .Sum   (ha1_sum),
    .Carry (ha1_carry)
  );

  assign s  = ha1_sum;
  assign co = ha0_carry | ha1_carry;

  // New result bit enters at the MSB; after WIDTH shifts bit 0 lands at rs[0].
  assign rs_d = WIDTH'({s, rs} >> 1);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (cnt == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ra      <= '0;
      rb      <= '0;
      rs      <= '0;
      cnt     <= '0;
      c       <= 1'b0;
      cmsb    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      V       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ra  <= A;
        rb  <= B;
        c   <= Cin;
        cnt <= '0;
        rs  <= '0;
      end else if (state_q == StRun) begin
        ra  <= ra >> 1;
        rb  <= rb >> 1;
        rs  <= rs_d;
        c   <= co;
        cnt <= cnt + CW'(1);
        // Carry out of bit WIDTH-2 is the carry into the MSB.
        if (cnt == PenCnt) begin
          cmsb <= co;
        end
        if (cnt == LastCnt) begin
          Sum  <= rs_d;
          Cout <= co;
          V    <= cmsb ^ co;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: 32-bit instance for directed and random
// tests, plus an 8-bit instance for a random sweep.

module tb_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        cin;
  logic        busy, done;
  logic [31:0] sum;
  logic        cout, v;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        cin8;
  logic        busy8, done8;
  logic [7:0]  sum8;
  logic        cout8, v8;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Cout  (cout),
    .V     (v)
  );

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .Cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .Sum   (sum8),
    .Cout  (cout8),
    .V     (v8)
  );

  function automatic exp_t model32(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] t;
    exp_t        e;
    t      = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    e.sum  = t[31:0];
    e.cout = t[32];
    e.v    = (x[31] == y[31]) && (t[31] != x[31]);
    return e;
  endfunction

  // Presents a request, pushes its expected result, returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ci);
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
    q.push_back(model32(x, y, ci));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cycles counts edges after the accept edge.
  task automatic wait_done(output int cycles, output int busy_n, output bit sum_moved);
    logic [31:0] s0;
    s0 = sum; cycles = 0; busy_n = 0; sum_moved = 1'b0;
    while (!done && cycles < 100) begin
      if (busy) busy_n++;
      if (sum !== s0) sum_moved = 1'b1;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if ({cout, v, sum} !== 34'd0)
      $display("FAIL reset_outputs got cout=%b v=%b sum=%h want 0", cout, v, sum); else passed++;
    total++; if ({busy8, done8, cout8, v8, sum8} !== 12'd0)
      $display("FAIL reset_w8 got %h want 0", {busy8, done8, cout8, v8, sum8}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc, bn; bit mv; exp_t e;
    issue(32'h5, 32'h3, 1'b0);
    wait_done(cyc, bn, mv);
    e = q.pop_front();
    total++; if (done !== 1'b1) $display("FAIL basic_done got %b want 1", done); else passed++;
    total++; if (cyc !== 32) $display("FAIL basic_latency got %0d want 32", cyc); else passed++;
    total++; if (bn !== 32) $display("FAIL basic_busy_cycles got %0d want 32", bn); else passed++;
    total++; if (sum !== 32'h8 || e.sum !== 32'h8)
      $display("FAIL basic_sum got %h want %h", sum, 32'h8); else passed++;
    total++; if ({cout, v} !== {e.cout, e.v})
      $display("FAIL basic_flags got %b%b want %b%b", cout, v, e.cout, e.v); else passed++;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00)
      $display("FAIL basic_done_pulse got busy=%b done=%b want 0 0", busy, done); else passed++;
    total++; if (sum !== 32'h8) $display("FAIL basic_hold got %h want 8", sum); else passed++;
  endtask

  task automatic test_carry();
    logic [31:0] xs[3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] ys[3] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000};
    logic        cs[3] = '{1'b1, 1'b0, 1'b0};
    logic [33:0] want[3] = '{{1'b1, 1'b0, 32'h0}, {1'b0, 1'b1, 32'h8000_0000}, {1'b1, 1'b1, 32'h0}};
    for (int i = 0; i < 3; i++) begin
      int cyc, bn; bit mv; exp_t e;
      issue(xs[i], ys[i], cs[i]);
      wait_done(cyc, bn, mv);
      e = q.pop_front();
      total++; if (done !== 1'b1) $display("FAIL carry%0d_done got %b want 1", i, done); else passed++;
      total++; if ({cout, v, sum} !== want[i] || {e.cout, e.v, e.sum} !== want[i])
        $display("FAIL carry%0d got cout=%b v=%b sum=%h want %h", i, cout, v, sum, want[i]);
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bn; bit mv; exp_t e;
    issue(32'h1, 32'h1, 1'b0);
    repeat (9) @(negedge clk);
    a = 32'hF; b = 32'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL ignore_busy got %b want 1", busy); else passed++;
    wait_done(cyc, bn, mv);
    e = q.pop_front();
    total++; if (done !== 1'b1) $display("FAIL ignore_done got %b want 1", done); else passed++;
    total++; if (cyc !== 22) $display("FAIL ignore_latency got %0d want 22", cyc); else passed++;
    total++; if (sum !== 32'h2 || e.sum !== 32'h2)
      $display("FAIL ignore_sum got %h want 2", sum); else passed++;
  endtask

  // Entered at the negedge where done is high.
  task automatic test_back_to_back();
    int cyc, bn; bit mv; exp_t e;
    a = 32'hF; b = 32'hF; cin = 1'b0; start = 1'b1;
    q.push_back(model32(32'hF, 32'hF, 1'b0));
    @(negedge clk);
    start = 1'b0;
    total++; if ({busy, done} !== 2'b10)
      $display("FAIL b2b_busy got busy=%b done=%b want 1 0", busy, done); else passed++;
    wait_done(cyc, bn, mv);
    e = q.pop_front();
    total++; if (cyc !== 32) $display("FAIL b2b_latency got %0d want 32", cyc); else passed++;
    total++; if (sum !== 32'h1E || e.sum !== 32'h1E)
      $display("FAIL b2b_sum got %h want 1e", sum); else passed++;
    total++; if (mv !== 1'b0) $display("FAIL b2b_sum_stable got %b want 0", mv); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int cyc, bn, dn; bit mv; exp_t e;
    issue(32'h1234_5678, 32'h1111_1111, 1'b1);
    repeat (16) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    void'(q.pop_front());
    total++; if ({busy, done} !== 2'b00)
      $display("FAIL midrst_ctrl got busy=%b done=%b want 0 0", busy, done); else passed++;
    total++; if ({cout, v, sum} !== 34'd0)
      $display("FAIL midrst_outputs got cout=%b v=%b sum=%h want 0", cout, v, sum); else passed++;
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    total++; if (dn !== 0) $display("FAIL midrst_no_done got %0d pulses want 0", dn); else passed++;
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    wait_done(cyc, bn, mv);
    e = q.pop_front();
    total++; if ({done, cout, v, sum} !== {1'b1, e.cout, e.v, e.sum})
      $display("FAIL midrst_fresh got done=%b cout=%b v=%b sum=%h want 1 %b %b %h",
               done, cout, v, sum, e.cout, e.v, e.sum);
    else passed++;
  endtask

  task automatic test_random32();
    for (int i = 0; i < 1000; i++) begin
      int cyc, bn; bit mv; exp_t e;
      issue($urandom, $urandom, 1'($urandom_range(1)));
      wait_done(cyc, bn, mv);
      e = q.pop_front();
      total++; if ({done, cout, v, sum} !== {1'b1, e.cout, e.v, e.sum} || mv !== 1'b0)
        $display("FAIL rand32_%0d got done=%b cout=%b v=%b sum=%h moved=%b want 1 %b %b %h 0",
                 i, done, cout, v, sum, mv, e.cout, e.v, e.sum);
      else passed++;
    end
  endtask

  task automatic test_random8();
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] x, y, s0; logic ci; logic [8:0] t; logic ev; int cyc; bit mv;
      x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom_range(1));
      t  = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      ev = (x[7] == y[7]) && (t[7] != x[7]);
      @(negedge clk);
      a8 = x; b8 = y; cin8 = ci; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      s0 = sum8; cyc = 0; mv = 1'b0;
      while (!done8 && cyc < 40) begin
        if (sum8 !== s0) mv = 1'b1;
        @(negedge clk);
        cyc++;
      end
      total++; if ({done8, cout8, v8, sum8} !== {1'b1, t[8], ev, t[7:0]} || cyc !== 8 || mv !== 1'b0)
        $display("FAIL rand8_%0d got done=%b cout=%b v=%b sum=%h lat=%0d moved=%b want 1 %b %b %h 8 0",
                 i, done8, cout8, v8, sum8, cyc, mv, t[8], ev, t[7:0]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random32();
    test_random8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
